// File: rtl/tea_cipher.sv
// -----------------------------------------------------------------------------
// tea_cipher
//
// Iterative TEA block cipher engine. It accepts a 64-bit block, a 128-bit key
// and a direction through a valid/ready handshake. It runs ROUNDS TEA cycles,
// UNROLL of them per clock. The finished block is held on dout until the sink
// accepts it.
//
// Parameters
//   ROUNDS  TEA cycles per block (1..64)
//   UNROLL  rounds applied per clock (1, 2, 4 or 8; must divide ROUNDS)
//   DELTA   key-schedule constant
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   source presents a block
//   in_ready   engine idle and able to accept a block
//   mode       0 = encrypt, 1 = decrypt (sampled on accept)
//   key        {k0, k1, k2, k3} (sampled on accept)
//   din        {v0, v1} (sampled on accept)
//   out_valid  dout holds a finished block
//   out_ready  sink accepts dout
//   dout       result {v0, v1}
//   busy       engine is working on or holding a block
// -----------------------------------------------------------------------------
module tea_cipher #(
    parameter int          ROUNDS = 32,
    parameter int          UNROLL = 1,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [127:0] key,
    input  logic [63:0]  din,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  dout,
    output logic         busy
);

    // Reject parameter combinations the round counter cannot handle exactly.
    generate
        if (ROUNDS < 1 || ROUNDS > 64) begin : g_bad_rounds
            $error("tea_cipher: ROUNDS must lie in 1..64");
        end
        if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
            $error("tea_cipher: UNROLL must be 1, 2, 4 or 8");
        end else if ((ROUNDS % UNROLL) != 0) begin : g_bad_ratio
            $error("tea_cipher: UNROLL must divide ROUNDS");
        end
    endgenerate

    localparam logic [6:0]  ROUNDS_C = 7'(ROUNDS);
    localparam logic [6:0]  UNROLL_C = 7'(UNROLL);

    // A decrypt starts from the sum that encryption ends with: DELTA * ROUNDS mod 2^32.
    localparam logic [63:0] SUM_PROD     = 64'(DELTA) * 64'(ROUNDS);
    localparam logic [31:0] DEC_SUM_INIT = SUM_PROD[31:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:0]  v0_q, v1_q, sum_q;
    logic [127:0] key_q;
    logic         mode_q;
    logic [6:0]   count_q;
    logic [63:0]  dout_q;

    logic [31:0]  k0, k1, k2, k3;
    logic [31:0]  v0_n, v1_n, sum_n;
    logic [6:0]   count_step;
    logic         last_step;

    assign k0 = key_q[127:96];
    assign k1 = key_q[95:64];
    assign k2 = key_q[63:32];
    assign k3 = key_q[31:0];

    // TEA mixing term shared by both half-rounds.
    function automatic logic [31:0] mix(input logic [31:0] x,
                                        input logic [31:0] s,
                                        input logic [31:0] ka,
                                        input logic [31:0] kb);
        return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
    endfunction

    // UNROLL rounds chained combinationally. Each round feeds the values it
    // has just updated into the next half-round.
    always_comb begin
        v0_n  = v0_q;
        v1_n  = v1_q;
        sum_n = sum_q;
        for (int r = 0; r < UNROLL; r++) begin
            if (!mode_q) begin
                sum_n = sum_n + DELTA;
                v0_n  = v0_n + mix(v1_n, sum_n, k0, k1);
                v1_n  = v1_n + mix(v0_n, sum_n, k2, k3);
            end else begin
                v1_n  = v1_n - mix(v0_n, sum_n, k2, k3);
                v0_n  = v0_n - mix(v1_n, sum_n, k0, k1);
                sum_n = sum_n - DELTA;
            end
        end
    end

    assign count_step = count_q + UNROLL_C;
    assign last_step  = (count_step == ROUNDS_C);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs. The outputs depend only on the
    // registered state, so nothing flows combinationally from in_valid or out_ready.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath. Operands are captured on accept and then iterated in RUN.
    // dout is loaded only on the final step, so a partial result never appears on it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v0_q    <= '0;
            v1_q    <= '0;
            sum_q   <= '0;
            key_q   <= '0;
            mode_q  <= 1'b0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        v0_q    <= din[63:32];
                        v1_q    <= din[31:0];
                        key_q   <= key;
                        mode_q  <= mode;
                        count_q <= '0;
                        sum_q   <= mode ? DEC_SUM_INIT : 32'd0;
                    end
                end
                RUN: begin
                    v0_q    <= v0_n;
                    v1_q    <= v1_n;
                    sum_q   <= sum_n;
                    count_q <= count_step;
                    if (last_step) begin
                        dout_q <= {v0_n, v1_n};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dout = dout_q;

endmodule

// File: doc/tea_cipher.md
# tea_cipher

Parametrised TEA block cipher engine with runtime key, data and direction (encrypt/decrypt), a valid/ready handshake on both sides, and configurable round count and rounds-per-cycle unrolling. It replaces fixed-vector, self-checking TEA encryption with a reusable datapath core. Upstream logic or a host interface feeds it 64-bit blocks. Results go to a downstream consumer that may apply backpressure.

## Interface

- ROUNDS, 32: number of TEA cycles per block. Legal range 1..64.
- UNROLL, 1: rounds executed per clock. Legal values are 1, 2, 4 or 8, and UNROLL must divide ROUNDS. Illegal combinations stop elaboration with an error.
- DELTA, 32'h9E3779B9: key-schedule constant.

- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  source presents a block.
- in_ready  out  1  engine can accept a block; high only in IDLE.
- mode  in  1  0 = encrypt, 1 = decrypt; sampled on accept.
- key  in  128  k0 = key[127:96], k1 = key[95:64], k2 = key[63:32], k3 = key[31:0]; sampled on accept.
- din  in  64  v0 = din[63:32], v1 = din[31:0]; sampled on accept.
- out_valid  out  1  dout holds a finished block.
- out_ready  in  1  sink accepts dout.
- dout  out  64  result: {v0, v1}.
- busy  out  1  high in RUN or DONE.

## Operation

- **States:** IDLE, RUN, DONE. Reset puts the engine in IDLE.
- **Reset values:** in_ready = 1, out_valid = 0, busy = 0, dout = 0. The internal v0, v1, sum, key, mode and round counter registers all reset to 0.
- **IDLE:**
  - An edge with in_valid && in_ready latches din, key and mode, clears the round counter and moves to RUN.
  - Initial sum is 0 for encrypt. For decrypt it is (DELTA × ROUNDS) mod 2^32, which is 32'hC6EF3720 for ROUNDS = 32.
- **RUN:** each edge applies UNROLL rounds in sequence, combinationally chained, and adds UNROLL to the counter.
  - **Encrypt round:**
    - sum += DELTA
    - v0 += ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1)
    - v1 += ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3)
    - The v1 update uses the new v0.
  - **Decrypt round:**
    - v1 −= ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3)
    - v0 −= ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1), using the new v1
    - then sum −= DELTA
  - **Arithmetic:** all operations are 32-bit modular with no overflow detection. Shifts are logical.
  - **Exit:** on the edge where the counter reaches ROUNDS, the engine moves to DONE. dout is loaded with {v0, v1} and out_valid is set.
- **DONE:**
  - dout and out_valid hold stable until out_valid && out_ready on an edge.
  - That edge moves the engine to IDLE and clears out_valid. dout keeps its last value.
- **Ignored inputs:**
  - in_valid outside IDLE has no effect. din, key and mode changes after accept have no effect.
  - out_ready outside DONE is ignored.
- **Reset mid-operation:** asynchronous reset at any time aborts the block and forces the reset values immediately. No partial result is ever presented.

## Timing

- Accept on edge N. out_valid is high after edge N + ROUNDS/UNROLL: 32 cycles at the defaults, 8 cycles with UNROLL = 4.
- With out_ready held high, the DONE → IDLE transition happens on edge N + ROUNDS/UNROLL + 1. in_ready is high after that edge, so the next accept is at edge N + ROUNDS/UNROLL + 2 at the earliest.
- Throughput is one block per ROUNDS/UNROLL + 2 cycles.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- The critical path is UNROLL chained round stages. UNROLL = 1 must close timing at the project clock.

## Test plan

- **Zero vector, encrypt:** reset, then accept key = 0 and din = 0 with mode 0. Expect dout = 64'h41EA3A0A_94BAA940, with out_valid rising exactly 32 cycles after the accept edge.
- **Project vector:** key = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444} and din = 64'h12345678_9ABCDEF0.
  - Encrypt must give dout = 64'h5CF85E83_E967E1FD.
  - Decrypting that ciphertext with mode 1 must return 64'h12345678_9ABCDEF0.
- **UNROLL sweep:** repeat the project vector with UNROLL = 2, 4 and 8. dout must be identical, with latency of 16, 8 and 4 cycles respectively.
- **Backpressure:** hold out_ready low for 10 cycles after out_valid rises.
  - dout stays stable and in_ready stays 0 throughout.
  - Changing din, key and mode during RUN does not alter the result.
  - The handshake completes on the first edge with out_ready high.
- **Reset mid-run:** assert reset 5 cycles into RUN.
  - Outputs go to in_ready = 1, out_valid = 0, busy = 0, dout = 0 immediately.
  - The next accepted block produces the correct result.
- **Back-to-back:** hold in_valid and out_ready high with 4 random blocks and random modes.
  - Each result matches the reference model.
  - Accepts are spaced exactly ROUNDS/UNROLL + 2 cycles apart.
